// File: rtl/adder_share_arb_if.sv
// ---------------------------------------------------------------------------
// adder_share_arb_if
// Bundle between the requesters/consumer side and the shared-adder arbiter.
//
// Parameters:
//   N_REQ - number of requesters
//   ID_W  - width of the requester index
//
// Signals:
//   i_req   [N_REQ]     per-requester request
//   i_a     [32*N_REQ]  packed operand A (requester k at [32k+31:32k])
//   i_b     [32*N_REQ]  packed operand B
//   i_cin   [N_REQ]     per-requester carry-in
//   o_gnt   [N_REQ]     one-hot accept pulse (combinational)
//   o_valid             result register holds an unconsumed result
//   i_rdy               downstream accepts result on o_valid && i_rdy
//   o_id    [ID_W]      requester owning o_sum
//   o_sum   [32]        registered sum
//   o_cout              registered carry-out
//   o_ovf               registered signed overflow (ADDER_SHARE_ARB_OVF_EN only)
//
// Modports: slave = arbiter side, master = requesters/consumer side.
// Optional feature macro: ADDER_SHARE_ARB_OVF_EN.
// ---------------------------------------------------------------------------
interface adder_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    i_req;
  logic [32*N_REQ-1:0] i_a;
  logic [32*N_REQ-1:0] i_b;
  logic [N_REQ-1:0]    i_cin;
  logic [N_REQ-1:0]    o_gnt;
  logic                o_valid;
  logic                i_rdy;
  logic [ID_W-1:0]     o_id;
  logic [31:0]         o_sum;
  logic                o_cout;
`ifdef ADDER_SHARE_ARB_OVF_EN
  logic                o_ovf;
`endif

`ifdef ADDER_SHARE_ARB_OVF_EN
  modport slave (
    input  i_req, i_a, i_b, i_cin, i_rdy,
    output o_gnt, o_valid, o_id, o_sum, o_cout, o_ovf
  );
  modport master (
    output i_req, i_a, i_b, i_cin, i_rdy,
    input  o_gnt, o_valid, o_id, o_sum, o_cout, o_ovf
  );
`else
  modport slave (
    input  i_req, i_a, i_b, i_cin, i_rdy,
    output o_gnt, o_valid, o_id, o_sum, o_cout
  );
  modport master (
    output i_req, i_a, i_b, i_cin, i_rdy,
    input  o_gnt, o_valid, o_id, o_sum, o_cout
  );
`endif
endinterface

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
// Round-robin arbiter time-sharing one 32-bit adder between N_REQ requesters.
// The winner's operands are muxed into the adder and the result is captured
// in a single-entry output register with valid/ready backpressure.
// One add per cycle, one cycle from grant to o_valid.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - adder_share_arb_if.slave (requests, operands, grant, result)
//
// Optional feature macro: ADDER_SHARE_ARB_OVF_EN adds registered o_ovf
// (signed overflow of the winner's add) to the interface.
// ---------------------------------------------------------------------------

// Plain 32-bit ripple/carry adder shared by all requesters.
module adder_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_s,
  output logic        o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module adder_share_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  adder_share_arb_if.slave   bus
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] pick_vec;
  logic [N_REQ-1:0] below;
  logic [N_REQ-1:0] onehot;
  logic [ID_W-1:0]  id_acc [N_REQ];
  logic [31:0]      a_acc  [N_REQ];
  logic [31:0]      b_acc  [N_REQ];
  logic [N_REQ-1:0] cin_sel;

  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             accept;
  logic [31:0]      add_a, add_b, add_s;
  logic             add_cin, add_c;

  // Round-robin search: prefer the lowest request at or above ptr; if there
  // is none, the search has wrapped and the lowest request overall wins.
  assign pick_vec = (|(bus.i_req & hi_mask)) ? (bus.i_req & hi_mask) : bus.i_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_arb
      assign hi_mask[gi] = (ID_W'(gi) >= ptr_q);

      // Lowest-set-bit isolation of pick_vec.
      if (gi == 0) begin : g_first
        assign below[gi]  = 1'b0;
        assign id_acc[gi] = '0;
        assign a_acc[gi]  = {32{onehot[gi]}} & bus.i_a[31:0];
        assign b_acc[gi]  = {32{onehot[gi]}} & bus.i_b[31:0];
      end else begin : g_rest
        assign below[gi]  = below[gi-1] | pick_vec[gi-1];
        assign id_acc[gi] = id_acc[gi-1] | (onehot[gi] ? ID_W'(gi) : '0);
        assign a_acc[gi]  = a_acc[gi-1] | ({32{onehot[gi]}} & bus.i_a[32*gi +: 32]);
        assign b_acc[gi]  = b_acc[gi-1] | ({32{onehot[gi]}} & bus.i_b[32*gi +: 32]);
      end
      assign onehot[gi]  = pick_vec[gi] & ~below[gi];
      assign cin_sel[gi] = onehot[gi] & bus.i_cin[gi];
    end
  endgenerate

  assign win_found = |bus.i_req;
  assign win_id    = id_acc[N_REQ-1];

  // AND-OR mux: with no winner onehot is zero, so the adder sees all zeros.
  assign add_a   = a_acc[N_REQ-1];
  assign add_b   = b_acc[N_REQ-1];
  assign add_cin = |cin_sel;

  adder_32bit u_adder (
    .i_a   (add_a),
    .i_b   (add_b),
    .i_cin (add_cin),
    .o_s   (add_s),
    .o_c   (add_c)
  );

  assign accept    = win_found && (!valid_q || bus.i_rdy) && !i_rst;
  assign bus.o_gnt = accept ? onehot : '0;

`ifdef ADDER_SHARE_ARB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
`ifdef ADDER_SHARE_ARB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      sum_d   = add_s;
      cout_d  = add_c;
      id_d    = win_id;
      valid_d = 1'b1;
      ptr_d   = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
`ifdef ADDER_SHARE_ARB_OVF_EN
      ovf_d   = (add_a[31] == add_b[31]) && (add_s[31] != add_a[31]);
`endif
    end else if (bus.i_rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ADDER_SHARE_ARB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef ADDER_SHARE_ARB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_id    = id_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_cout  = cout_q;
`ifdef ADDER_SHARE_ARB_OVF_EN
  assign bus.o_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arb
// Table-driven bench for adder_share_arb (N_REQ=4, ID_W=2) with hand-written
// sequences for reset-in-flight and the optional overflow output
// (ADDER_SHARE_ARB_OVF_EN).
// ---------------------------------------------------------------------------
module tb_adder_share_arb;

  logic clk;
  logic rst;

  adder_share_arb_if #(.N_REQ(4), .ID_W(2)) bus ();

  adder_share_arb #(.N_REQ(4), .ID_W(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   req;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   cin;
    logic         rdy;
    logic [3:0]   gnt;
    logic         valid;
    logic [1:0]   id;
    logic [31:0]  sum;
    logic         cout;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic [127:0] a, logic [127:0] b,
                              logic [3:0] cin, logic rdy, logic [3:0] gnt,
                              logic valid, logic [1:0] id, logic [31:0] sum,
                              logic cout);
    vec_t v;
    v.req = req; v.a = a; v.b = b; v.cin = cin; v.rdy = rdy;
    v.gnt = gnt; v.valid = valid; v.id = id; v.sum = sum; v.cout = cout;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational grant mid-cycle,
  // then check the registered result just after the next rising edge.
  task automatic step(input string tag, input int idx, input vec_t v, input logic r);
    rst       = r;
    bus.i_req = v.req;
    bus.i_a   = v.a;
    bus.i_b   = v.b;
    bus.i_cin = v.cin;
    bus.i_rdy = v.rdy;
    #1;
    chk({tag, "_gnt"}, idx, 32'(bus.o_gnt), 32'(v.gnt));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, idx, 32'(bus.o_valid), 32'(v.valid));
    chk({tag, "_id"},    idx, 32'(bus.o_id),    32'(v.id));
    chk({tag, "_sum"},   idx, bus.o_sum,        v.sum);
    chk({tag, "_cout"},  idx, 32'(bus.o_cout),  32'(v.cout));
    $display("%s %0d: rst=%b req=%b rdy=%b gnt=%b valid=%b id=%0d sum=%h cout=%b",
             tag, idx, r, v.req, v.rdy, v.gnt, bus.o_valid, bus.o_id, bus.o_sum, bus.o_cout);
  endtask

  localparam int NV = 21;
  vec_t tbl [NV];

  initial begin
    logic [127:0] ar, br, a13, b13, z;
    vec_t v;
    z   = '0;
    ar  = {32'd3, 32'd2, 32'd1, 32'd0};
    br  = {32'd10, 32'd10, 32'd10, 32'd10};
    a13 = {32'd0, 32'd100, 32'd0, 32'd7};
    b13 = {32'd0, 32'd5, 32'd0, 32'd8};

    // single add with wrap-around carry
    tbl[0]  = mk(4'b0001, {96'd0, 32'hFFFF_FFFF}, {96'd0, 32'h1}, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0, 1'b1);
    // round-robin, all requesting (ptr starts at 1)
    tbl[1]  = mk(4'b1111, ar, br, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd12, 1'b0);
    tbl[2]  = mk(4'b1111, ar, br, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd13, 1'b0);
    tbl[3]  = mk(4'b1111, ar, br, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd14, 1'b0);
    tbl[4]  = mk(4'b1111, ar, br, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd11, 1'b0);
    tbl[5]  = mk(4'b1111, ar, br, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd12, 1'b0);
    // drain: result consumed, registers hold
    tbl[6]  = mk(4'b0000, z, z, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd12, 1'b0);
    // grant requester 2, then five idle cycles
    tbl[7]  = mk(4'b0100, a13, b13, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd105, 1'b0);
    for (int i = 8; i <= 12; i++)
      tbl[i] = mk(4'b0000, z, z, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'd105, 1'b0);
    // ptr=3: search 3,0 -> requester 0
    tbl[13] = mk(4'b0101, a13, b13, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd15, 1'b0);
    // backpressure for three cycles, then release
    for (int i = 14; i <= 16; i++)
      tbl[i] = mk(4'b0100, a13, b13, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd15, 1'b0);
    tbl[17] = mk(4'b0100, a13, b13, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd105, 1'b0);
    // all-ones plus carry-in, grant to last index wraps ptr to 0
    tbl[18] = mk(4'b1000, {32'hFFFF_FFFF, 96'd0}, {32'hFFFF_FFFF, 96'd0}, 4'b1000, 1'b1,
                 4'b1000, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1);
    tbl[19] = mk(4'b0010, {64'd0, 32'd1, 32'd0}, {64'd0, 32'd2, 32'd0}, 4'b0000, 1'b1,
                 4'b0010, 1'b1, 2'd1, 32'd3, 1'b0);
    // hold the result with i_rdy low before the reset-in-flight sequence
    tbl[20] = mk(4'b1000, {32'd5, 96'd0}, {32'd6, 96'd0}, 4'b0000, 1'b0,
                 4'b0000, 1'b1, 2'd1, 32'd3, 1'b0);

    // reset with requests present: no grant, everything cleared
    rst       = 1'b1;
    bus.i_req = 4'b1111;
    bus.i_a   = ar;
    bus.i_b   = br;
    bus.i_cin = 4'b1111;
    bus.i_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_gnt", 0, 32'(bus.o_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_valid", 0, 32'(bus.o_valid), 32'd0);
    chk("rst_sum",   0, bus.o_sum,        32'd0);
    chk("rst_cout",  0, 32'(bus.o_cout),  32'd0);
    chk("rst_id",    0, 32'(bus.o_id),    32'd0);
    $display("reset: valid=%b sum=%h cout=%b id=%0d", bus.o_valid, bus.o_sum, bus.o_cout, bus.o_id);

    for (int i = 0; i < NV; i++)
      step("vec", i, tbl[i], 1'b0);

    // reset mid-flight: pending result dropped, no grant this cycle
    v = mk(4'b1000, {32'd5, 96'd0}, {32'd6, 96'd0}, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0, 1'b0);
    step("midrst", 0, v, 1'b1);
    // ptr was 2 before reset; after reset requester 1 must win over 3
    v = mk(4'b1010, {32'd5, 32'd0, 32'd20, 32'd0}, {32'd6, 32'd0, 32'd22, 32'd0}, 4'b0010, 1'b1,
           4'b0010, 1'b1, 2'd1, 32'd43, 1'b0);
    step("midrst", 1, v, 1'b0);
    v = mk(4'b0000, z, z, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd43, 1'b0);
    step("midrst", 2, v, 1'b0);

`ifdef ADDER_SHARE_ARB_OVF_EN
    v = mk(4'b0001, {96'd0, 32'h7FFF_FFFF}, {96'd0, 32'h1}, 4'b0000, 1'b1,
           4'b0001, 1'b1, 2'd0, 32'h8000_0000, 1'b0);
    step("ovf", 0, v, 1'b0);
    chk("ovf_flag", 0, 32'(bus.o_ovf), 32'd1);
    v = mk(4'b0001, {96'd0, 32'h8000_0000}, {96'd0, 32'h8000_0000}, 4'b0000, 1'b1,
           4'b0001, 1'b1, 2'd0, 32'h0, 1'b1);
    step("ovf", 1, v, 1'b0);
    chk("ovf_flag", 1, 32'(bus.o_ovf), 32'd1);
    v = mk(4'b0001, {96'd0, 32'h1}, {96'd0, 32'h1}, 4'b0000, 1'b1,
           4'b0001, 1'b1, 2'd0, 32'h2, 1'b0);
    step("ovf", 2, v, 1'b0);
    chk("ovf_flag", 2, 32'(bus.o_ovf), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter that time-shares one adder_32bit instance between N_REQ requesters in the PID datapath, e.g. the P/I/D term accumulators and the output summer.
- Each requester presents operands plus carry-in under a req/gnt handshake.
- The block muxes the winner's operands into the adder and registers the result in a single-entry output stage with valid/ready backpressure.
- Throughput is one add per cycle; latency is 1 cycle from grant to o_valid.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index. Must satisfy 2**ID_W >= N_REQ.

Ports:
- i_clk, input, 1, clock. All state updates on the rising edge.
- i_rst, input, 1, reset. Synchronous, active-high.
- i_req, input, N_REQ, per-requester request. Held high with operands stable until the matching o_gnt bit is seen.
- i_a, input, 32*N_REQ, packed operand A. Requester k occupies bits [32k+31:32k].
- i_b, input, 32*N_REQ, packed operand B, same packing as i_a.
- i_cin, input, N_REQ, per-requester carry-in.
- o_gnt, output, N_REQ, one-hot accept pulse (combinational). Bit k high means requester k's operands are consumed this cycle.
- o_valid, output, 1, result register holds an unconsumed result.
- i_rdy, input, 1, downstream accepts the result when o_valid && i_rdy.
- o_id, output, ID_W, index of the requester owning o_sum.
- o_sum, output, 32, registered sum.
- o_cout, output, 1, registered carry-out.

Behaviour:
- Reset: while i_rst is high at a clock edge:
  - o_valid=0, o_sum=0, o_cout=0, o_id=0, round-robin pointer ptr=0.
  - o_gnt is forced to 0 combinationally whenever i_rst is high.
- Accept condition: accept = (|i_req) && (!o_valid || i_rdy) && !i_rst.
- Arbitration, within one cycle:
  - Search i_req starting at index ptr, then ptr+1, ... modulo N_REQ.
  - The first set bit k wins; o_gnt = onehot(k) iff accept, otherwise o_gnt = 0.
- Datapath:
  - Adder inputs are i_a[k], i_b[k], i_cin[k] of the winner.
  - When there is no winner, the adder inputs are driven to 0 (no X propagation).
- Output register, at the rising edge:
  - if accept: o_sum <= adder o_s, o_cout <= adder o_c, o_id <= k, o_valid <= 1, ptr <= (k+1) mod N_REQ.
  - else if i_rdy: o_valid <= 0. o_sum, o_cout and o_id hold their values.
  - else: all hold.
- Backpressure:
  - While o_valid=1 and i_rdy=0, o_gnt=0 and all registers hold.
  - Requesters keep waiting with no data loss.
- Simultaneous drain and fill: o_valid=1, i_rdy=1 and a pending request gives a new result loaded in the same cycle; o_valid stays 1. This is full throughput.
- Pointer:
  - Advances only on accept.
  - Idle cycles (no request) leave ptr unchanged.
  - Wrap: a grant to N_REQ-1 sets ptr to 0.
- Fairness: a continuously requesting requester is granted within N_REQ accepted transactions.
- Request drop: a requester may deassert i_req before its grant. No state is kept per requester.
- Reset mid-operation:
  - A pending result is discarded (o_valid=0).
  - No o_gnt is issued in the reset cycle.
  - Arbitration resumes from ptr=0.
- Width rule: sum is modulo 2^32; carry-out is reported in o_cout. Signedness is not interpreted except by the optional feature.

Optional Feature:
- Macro: ADDER_SHARE_ARB_OVF_EN.
- When defined:
  - Extra output port o_ovf, 1 bit, registered alongside o_sum.
  - o_ovf = (a[31]==b[31]) && (sum[31]!=a[31]), computed on the winner's operands.
  - Reset value 0; holds with o_sum.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single add: i_req=4'b0001, requester0 a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0, i_rdy=1 -> o_gnt=4'b0001 same cycle; next cycle o_valid=1, o_id=0, o_sum=32'h0, o_cout=1.
- Round-robin: all 4 requesting continuously with a=k, b=10, cin=1, i_rdy=1 -> grants 0,1,2,3,0,... on consecutive cycles; sums 11,12,13,14; o_id tracks k.
- Backpressure: hold i_rdy=0 for 3 cycles after a result -> o_gnt=0, o_sum/o_id stable; release i_rdy -> next grant in the same cycle, no lost or duplicated result.
- Pointer after idle: grant requester 2, idle 5 cycles, then i_req=4'b0101 -> requester 2 is not first; requester 0 wins? No: ptr=3, search 3,0 -> requester 0 granted.
- Reset mid-flight: o_valid=1 with i_rdy=0, assert i_rst for 1 cycle while i_req=4'b1000 -> o_gnt=0 that cycle; o_valid=0, o_sum=0 after the edge; next grant issued with ptr=0 -> requester 3 granted.
- (OVF_EN) a=32'h7FFF_FFFF, b=32'h1, cin=0 -> o_sum=32'h8000_0000, o_ovf=1, o_cout=0; a=32'h8000_0000, b=32'h8000_0000 -> o_sum=0, o_ovf=1, o_cout=1.
